memory_stage: RTL
=================

Name: memory_stage

Overview:
- Fourth stage of the 5-stage pipelined CPU, directly downstream of the execute stage; consumes the EXE/MEM pipeline registers.
- Issues the data-SRAM access and owns the HI/LO register pair (MULT/MULTU, MTHI/MTLO, MFHI/MFLO).
- Selects the non-load result, registers everything into the MEM/WB pipeline registers, and formats returning load data (LB/LBU/LH/LHU/LW/LWL/LWR) for the WB stage.

Parameters:
- None.
- Widths are fixed by the ISA: 32-bit data, 5-bit register address.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- exc_flush  in  1  exception commit: squash the instruction currently in MEM
- MemEn_EXE_MEM  in  1  memory access enable
- MemToReg_EXE_MEM  in  1  load writes memory data to the register file
- MemWrite_EXE_MEM  in  4  byte write enables, already lane-aligned
- RegWrite_EXE_MEM  in  4  register-file byte write enables
- RegWaddr_EXE_MEM  in  5  destination register
- MULT_EXE_MEM  in  2  01 = MULT (signed), 10 = MULTU, else none
- MFHL_EXE_MEM  in  2  01 = MFLO, 10 = MFHI
- MTHL_EXE_MEM  in  2  01 = MTLO, 10 = MTHI
- LB_EXE_MEM, LBU_EXE_MEM, LH_EXE_MEM, LHU_EXE_MEM  in  1 each  load kind
- LW_EXE_MEM  in  2  11 = LW, 10 = LWL, 01 = LWR
- ALUResult_EXE_MEM  in  32  effective address or ALU result
- MemWdata_EXE_MEM  in  32  store data, already lane-aligned
- PC_EXE_MEM  in  32  PC+4 of the instruction
- RegRdata1_EXE_MEM  in  32  rs value
- RegRdata2_EXE_MEM  in  32  rt value
- mfc0_EXE_MEM  in  1  instruction is MFC0
- cp0Rdata_EXE_MEM  in  32  CP0 read data
- data_sram_en  out  1  SRAM enable
- data_sram_wen  out  4  SRAM byte write enables
- data_sram_addr  out  32  SRAM address
- data_sram_wdata  out  32  SRAM write data
- data_sram_rdata  in  32  SRAM read data, valid one cycle after the request
- Bypass_MEM  out  32  forwarding value of the MEM-stage result
- mem_stall  out  1  freeze IF/ID/EXE (always 0 unless the optional feature is compiled in)
- MemToReg_MEM_WB  out  1  registered MemToReg
- RegWrite_MEM_WB  out  4  registered RegWrite
- RegWaddr_MEM_WB  out  5  registered destination register
- Result_MEM_WB  out  32  registered non-load result
- PC_MEM_WB  out  32  registered PC+4
- LoadData_WB  out  32  formatted load data, combinational from data_sram_rdata

Behaviour:
- Reset (rst == 0 at posedge): all MEM/WB registers, HI, LO, internal lane registers and FSM are cleared to 0. Reset mid-multiply aborts it with no HI/LO write.
- SRAM request (combinational):
  - data_sram_en = MemEn & ~exc_flush.
  - data_sram_wen = MemWrite & {4{~exc_flush}}.
  - data_sram_addr = ALUResult; data_sram_wdata = MemWdata.
- Non-load result, priority order: mfc0 → cp0Rdata; else MFHL == 10 → HI; else MFHL == 01 → LO; else ALUResult.
  - Bypass_MEM always equals this value.
  - Loads are not bypassed from MEM; ID interlocks on them.
- HI/LO update at posedge, suppressed when exc_flush = 1:
  - MULT: {HI,LO} <= signed 64-bit product of rs × rt.
  - MULTU: {HI,LO} <= unsigned 64-bit product of rs × rt.
  - MTHI: HI <= rs. MTLO: LO <= rs.
  - If MULT and MTHL are asserted together, MULT wins.
  - An MFHI/MFLO immediately after a MULT/MTHx reads the new value; no extra bypass is needed.
- MEM/WB register, latency 1:
  - Each cycle the MEM/WB register captures MemToReg, RegWrite, RegWaddr, the non-load result and PC.
  - It also captures load kind, ALUResult[1:0] and rt into WB lane registers.
  - When exc_flush = 1, RegWrite_MEM_WB and MemToReg_MEM_WB capture 0.
- LoadData_WB, with registered address a = ALUResult[1:0] and registered rt:
  - LB: sign-extended byte at lane a. LBU: the same byte, zero-extended.
  - LH: sign-extended halfword at lane a[1]. LHU: the same halfword, zero-extended.
  - LW: rdata.
  - LWL: a=0 {r[7:0],rt[23:0]}; a=1 {r[15:0],rt[15:0]}; a=2 {r[23:0],rt[7:0]}; a=3 r.
  - LWR: a=0 r; a=1 {rt[31:24],r[31:8]}; a=2 {rt[31:16],r[31:16]}; a=3 {rt[31:8],r[31:24]}.
  - Non-load: 0.

Optional Feature:
- Macro: MULT_2CYCLE_EN.
- When defined, the multiply is registered over two cycles using a 2-state FSM:
  - IDLE → BUSY on a MULT/MULTU with no flush.
  - In BUSY: mem_stall = 1, the partial product is held, the MEM/WB register captures a bubble (RegWrite = 0), and SRAM enable/wen are forced to 0.
  - BUSY → IDLE next cycle: HI/LO are written and the instruction proceeds.
  - A flush in BUSY aborts with no HI/LO write.
- When not defined: single-cycle multiply and mem_stall is tied to 0.

Test Plan:
- MULT, rs = 0xFFFFFFFE, rt = 3 → next cycle MFHI gives 0xFFFFFFFF and MFLO gives 0xFFFFFFFA. MULTU with the same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- MTHI, rs = 0x12345678, then MFHI → Bypass_MEM = 0x12345678, and the following cycle Result_MEM_WB = 0x12345678.
- LB at address 0x1001 with rdata = 0x0000_8000 → LoadData_WB = 0xFFFFFF80. LBU, same conditions → 0x00000080.
- LWR at address 0x2002, rt = 0xAABBCCDD, rdata = 0x11223344 → 0xAABB1122. LWL at address 0x2001, same data → 0x3344CCDD.
- Store with MemWrite = 0100 and exc_flush = 1 → data_sram_wen = 0, RegWrite_MEM_WB = 0. A MULT in the same cycle leaves HI/LO unchanged.
- With MULT_2CYCLE_EN: MULT → mem_stall high for exactly one cycle with a WB bubble, then HI/LO valid. rst = 0 during BUSY → FSM IDLE and HI = LO = 0.

Source files
------------

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage pipeline: data-SRAM request, HI/LO pair, MEM/WB register and load formatting.
// Optional two-cycle multiplier compiled in with `define MULT_2CYCLE_EN.
module memory_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_flush,
    input  logic        MemEn_EXE_MEM,
    input  logic        MemToReg_EXE_MEM,
    input  logic [3:0]  MemWrite_EXE_MEM,
    input  logic [3:0]  RegWrite_EXE_MEM,
    input  logic [4:0]  RegWaddr_EXE_MEM,
    input  logic [1:0]  MULT_EXE_MEM,
    input  logic [1:0]  MFHL_EXE_MEM,
    input  logic [1:0]  MTHL_EXE_MEM,
    input  logic        LB_EXE_MEM,
    input  logic        LBU_EXE_MEM,
    input  logic        LH_EXE_MEM,
    input  logic        LHU_EXE_MEM,
    input  logic [1:0]  LW_EXE_MEM,
    input  logic [31:0] ALUResult_EXE_MEM,
    input  logic [31:0] MemWdata_EXE_MEM,
    input  logic [31:0] PC_EXE_MEM,
    input  logic [31:0] RegRdata1_EXE_MEM,
    input  logic [31:0] RegRdata2_EXE_MEM,
    input  logic        mfc0_EXE_MEM,
    input  logic [31:0] cp0Rdata_EXE_MEM,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,
    output logic [31:0] Bypass_MEM,
    output logic        mem_stall,
    output logic        MemToReg_MEM_WB,
    output logic [3:0]  RegWrite_MEM_WB,
    output logic [4:0]  RegWaddr_MEM_WB,
    output logic [31:0] Result_MEM_WB,
    output logic [31:0] PC_MEM_WB,
    output logic [31:0] LoadData_WB
);

    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] nonload_result;
    logic        is_mult;
    logic        is_multu;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] prod;
    logic        mul_hold;
    logic        kill;

    // WB lane registers used to format the load data returning from the SRAM
    logic        lb_q;
    logic        lbu_q;
    logic        lh_q;
    logic        lhu_q;
    logic [1:0]  lw_q;
    logic [1:0]  addr_q;
    logic [31:0] rt_q;

    assign is_mult  = (MULT_EXE_MEM == 2'b01);
    assign is_multu = (MULT_EXE_MEM == 2'b10);

    // Operands widened to 64 bits so the low half of the product is the full result
    assign prod_s = {{32{RegRdata1_EXE_MEM[31]}}, RegRdata1_EXE_MEM}
                  * {{32{RegRdata2_EXE_MEM[31]}}, RegRdata2_EXE_MEM};
    assign prod_u = {32'b0, RegRdata1_EXE_MEM} * {32'b0, RegRdata2_EXE_MEM};
    assign prod   = is_mult ? prod_s : prod_u;

`ifdef MULT_2CYCLE_EN
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mul_state_t;
    mul_state_t  mul_state;
    logic [63:0] prod_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mul_state <= IDLE;
            prod_q    <= 64'b0;
            hi        <= 32'b0;
            lo        <= 32'b0;
        end else begin
            case (mul_state)
                IDLE: begin
                    if (!exc_flush) begin
                        if (is_mult || is_multu) begin
                            mul_state <= BUSY;
                            prod_q    <= prod;
                        end else if (MTHL_EXE_MEM == 2'b10) begin
                            hi <= RegRdata1_EXE_MEM;
                        end else if (MTHL_EXE_MEM == 2'b01) begin
                            lo <= RegRdata1_EXE_MEM;
                        end
                    end
                end
                BUSY: begin
                    mul_state <= IDLE;
                    if (!exc_flush) begin
                        hi <= prod_q[63:32];
                        lo <= prod_q[31:0];
                    end
                end
                default: mul_state <= IDLE;
            endcase
        end
    end

    assign mem_stall = (mul_state == BUSY);
    assign mul_hold  = mem_stall;
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi <= 32'b0;
            lo <= 32'b0;
        end else if (!exc_flush) begin
            if (is_mult || is_multu) begin
                hi <= prod[63:32];
                lo <= prod[31:0];
            end else if (MTHL_EXE_MEM == 2'b10) begin
                hi <= RegRdata1_EXE_MEM;
            end else if (MTHL_EXE_MEM == 2'b01) begin
                lo <= RegRdata1_EXE_MEM;
            end
        end
    end

    assign mem_stall = 1'b0;
    assign mul_hold  = 1'b0;
`endif

    assign kill = exc_flush | mul_hold;

    assign data_sram_en    = MemEn_EXE_MEM & ~kill;
    assign data_sram_wen   = MemWrite_EXE_MEM & {4{~kill}};
    assign data_sram_addr  = ALUResult_EXE_MEM;
    assign data_sram_wdata = MemWdata_EXE_MEM;

    always_comb begin
        nonload_result = ALUResult_EXE_MEM;
        if (mfc0_EXE_MEM) begin
            nonload_result = cp0Rdata_EXE_MEM;
        end else if (MFHL_EXE_MEM == 2'b10) begin
            nonload_result = hi;
        end else if (MFHL_EXE_MEM == 2'b01) begin
            nonload_result = lo;
        end
    end

    assign Bypass_MEM = nonload_result;

    always_ff @(posedge clk) begin
        if (!rst) begin
            MemToReg_MEM_WB <= 1'b0;
            RegWrite_MEM_WB <= 4'b0;
            RegWaddr_MEM_WB <= 5'b0;
            Result_MEM_WB   <= 32'b0;
            PC_MEM_WB       <= 32'b0;
            lb_q            <= 1'b0;
            lbu_q           <= 1'b0;
            lh_q            <= 1'b0;
            lhu_q           <= 1'b0;
            lw_q            <= 2'b0;
            addr_q          <= 2'b0;
            rt_q            <= 32'b0;
        end else begin
            MemToReg_MEM_WB <= MemToReg_EXE_MEM & ~kill;
            RegWrite_MEM_WB <= RegWrite_EXE_MEM & {4{~kill}};
            RegWaddr_MEM_WB <= RegWaddr_EXE_MEM;
            Result_MEM_WB   <= nonload_result;
            PC_MEM_WB       <= PC_EXE_MEM;
            // A stall bubble carries no load; a flushed load is already neutralised by RegWrite
            lb_q            <= LB_EXE_MEM & ~mul_hold;
            lbu_q           <= LBU_EXE_MEM & ~mul_hold;
            lh_q            <= LH_EXE_MEM & ~mul_hold;
            lhu_q           <= LHU_EXE_MEM & ~mul_hold;
            lw_q            <= LW_EXE_MEM & {2{~mul_hold}};
            addr_q          <= ALUResult_EXE_MEM[1:0];
            rt_q            <= RegRdata2_EXE_MEM;
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        case (addr_q)
            2'd0:    ld_byte = data_sram_rdata[7:0];
            2'd1:    ld_byte = data_sram_rdata[15:8];
            2'd2:    ld_byte = data_sram_rdata[23:16];
            default: ld_byte = data_sram_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    end

    always_comb begin
        LoadData_WB = 32'b0;
        if (lb_q) begin
            LoadData_WB = {{24{ld_byte[7]}}, ld_byte};
        end else if (lbu_q) begin
            LoadData_WB = {24'b0, ld_byte};
        end else if (lh_q) begin
            LoadData_WB = {{16{ld_half[15]}}, ld_half};
        end else if (lhu_q) begin
            LoadData_WB = {16'b0, ld_half};
        end else begin
            case (lw_q)
                2'b11: LoadData_WB = data_sram_rdata;
                2'b10: begin
                    case (addr_q)
                        2'd0:    LoadData_WB = {data_sram_rdata[7:0],  rt_q[23:0]};
                        2'd1:    LoadData_WB = {data_sram_rdata[15:0], rt_q[15:0]};
                        2'd2:    LoadData_WB = {data_sram_rdata[23:0], rt_q[7:0]};
                        default: LoadData_WB = data_sram_rdata;
                    endcase
                end
                2'b01: begin
                    case (addr_q)
                        2'd0:    LoadData_WB = data_sram_rdata;
                        2'd1:    LoadData_WB = {rt_q[31:24], data_sram_rdata[31:8]};
                        2'd2:    LoadData_WB = {rt_q[31:16], data_sram_rdata[31:16]};
                        default: LoadData_WB = {rt_q[31:8],  data_sram_rdata[31:24]};
                    endcase
                end
                default: LoadData_WB = 32'b0;
            endcase
        end
    end

endmodule
